// File: rtl/uni_gate_arbiter.sv
// Round-robin arbiter sharing one bitwise gate unit among NREQ clients.
// Accept in IDLE, compute in EXEC, hold the registered response in RESP.
module uni_gate_arbiter #(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NREQ-1:0]       i_req_valid,
  output logic [NREQ-1:0]       o_req_ready,
  input  logic [3*NREQ-1:0]     i_req_op,
  input  logic [WIDTH*NREQ-1:0] i_req_a,
  input  logic [WIDTH*NREQ-1:0] i_req_b,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [IDW-1:0]        o_rsp_id,
  output logic [WIDTH-1:0]      o_rsp_data,
  output logic                  o_rsp_err,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic [IDW-1:0]   grant;
  logic             grant_vld;
  logic [IDW:0]     scan;
  logic [NREQ-1:0]  req_ready;
  logic [WIDTH-1:0] alu_data;
  logic             alu_err;

  // Rotating priority: smallest offset from ptr wins (scan high to low)
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    scan      = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      scan = {1'b0, ptr_q} + (IDW+1)'(i);
      if (scan >= (IDW+1)'(NREQ))
        scan = scan - (IDW+1)'(NREQ);
      if (i_req_valid[scan[IDW-1:0]]) begin
        grant     = scan[IDW-1:0];
        grant_vld = 1'b1;
      end
    end
  end

  // Shared gate unit on the latched operands
  always_comb begin
    alu_data = '0;
    alu_err  = 1'b0;
    case (op_q)
      3'd0:    alu_data = ~a_q;
      3'd1:    alu_data = a_q | b_q;
      3'd2:    alu_data = a_q & b_q;
      3'd3:    alu_data = ~(a_q | b_q);
      3'd4:    alu_data = ~(a_q & b_q);
      3'd5:    alu_data = a_q ^ b_q;
      3'd6:    alu_data = ~(a_q ^ b_q);
      default: alu_err  = 1'b1;
    endcase
  end

  // Next-state, capture and handshake logic
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    req_ready  = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          req_ready = NREQ'(1) << grant;
          id_d      = grant;
          op_d      = i_req_op[3*grant +: 3];
          a_d       = i_req_a[WIDTH*grant +: WIDTH];
          b_d       = i_req_b[WIDTH*grant +: WIDTH];
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_id_d   = id_q;
        rsp_data_d = alu_data;
        rsp_err_d  = alu_err;
        state_d    = RESP;
      end
      RESP: begin
        if (i_rsp_ready) begin
          ptr_d   = (rsp_id_q == IDW'(NREQ - 1)) ? '0
                                                 : rsp_id_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any transaction in flight
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      id_q       <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign o_req_ready = i_rst_n ? req_ready : '0;
  assign o_rsp_valid = (state_q == RESP);
  assign o_busy      = (state_q != IDLE);
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_uni_gate_arbiter.sv
// Bench for uni_gate_arbiter: directed steps then random traffic
// checked against a transaction-level round-robin model.
module tb_uni_gate_arbiter;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   i_req_valid;
  logic [N-1:0]   o_req_ready;
  logic [3*N-1:0] i_req_op;
  logic [W*N-1:0] i_req_a;
  logic [W*N-1:0] i_req_b;
  logic           o_rsp_valid;
  logic           i_rsp_ready;
  logic [IDW-1:0] o_rsp_id;
  logic [W-1:0]   o_rsp_data;
  logic           o_rsp_err;
  logic           o_busy;

  int tests  = 0;
  int fails  = 0;
  int mptr   = 0;
  int last_g = -1;
  logic [IDW-1:0] last_id;
  logic [W-1:0]   last_data;
  logic           last_err;
  logic [W-1:0]   sweep_exp [6];

  uni_gate_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_op    (i_req_op),
    .i_req_a     (i_req_a),
    .i_req_b     (i_req_b),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_id    (o_rsp_id),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_err   (o_rsp_err),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, 32'(o_req_ready), 0);
    check({tag, "_valid"}, 32'(o_rsp_valid), 0);
    check({tag, "_id"},    32'(o_rsp_id),    0);
    check({tag, "_data"},  32'(o_rsp_data),  0);
    check({tag, "_err"},   32'(o_rsp_err),   0);
    check({tag, "_busy"},  32'(o_busy),      0);
  endtask

  task automatic set_req(input int k, input logic v, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    i_req_valid[k]      = v;
    i_req_op[3*k +: 3]  = op;
    i_req_a[W*k +: W]   = a;
    i_req_b[W*k +: W]   = b;
  endtask

  // Reference gate unit: {err, data}
  function automatic logic [W:0] ref_alu(input logic [2:0] op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      3'd0:    return {1'b0, ~a};
      3'd1:    return {1'b0, a | b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, ~(a | b)};
      3'd4:    return {1'b0, ~(a & b)};
      3'd5:    return {1'b0, a ^ b};
      3'd6:    return {1'b0, ~(a ^ b)};
      default: return {1'b1, {W{1'b0}}};
    endcase
  endfunction

  // First valid requester at or after the model pointer, wrapping
  function automatic int model_grant();
    for (int i = 0; i < N; i++) begin
      int k;
      k = (mptr + i) % N;
      if (i_req_valid[k]) return k;
    end
    return -1;
  endfunction

  // Called at a falling edge in IDLE with requests driven; ends at a
  // falling edge back in IDLE after bp stalled response cycles.
  task automatic run_txn(input int bp);
    int         g;
    logic [W:0] r;
    g = model_grant();
    #1;
    check("idle_busy",  32'(o_busy),      0);
    check("idle_rspv",  32'(o_rsp_valid), 0);
    check("grant_rdy",  32'(o_req_ready), (g < 0) ? 0 : (32'(1) << g));
    last_g = g;
    if (g < 0) begin
      @(negedge clk);
      return;
    end
    r = ref_alu(i_req_op[3*g +: 3], i_req_a[W*g +: W], i_req_b[W*g +: W]);
    @(negedge clk);
    check("exec_busy", 32'(o_busy),      1);
    check("exec_rdy",  32'(o_req_ready), 0);
    check("exec_rspv", 32'(o_rsp_valid), 0);
    @(negedge clk);
    for (int j = 0; j <= bp; j++) begin
      check("rsp_valid", 32'(o_rsp_valid), 1);
      check("rsp_id",    32'(o_rsp_id),    32'(g));
      check("rsp_data",  32'(o_rsp_data),  32'(r[W-1:0]));
      check("rsp_err",   32'(o_rsp_err),   32'(r[W]));
      check("rsp_rdy",   32'(o_req_ready), 0);
      check("rsp_busy",  32'(o_busy),      1);
      last_id   = o_rsp_id;
      last_data = o_rsp_data;
      last_err  = o_rsp_err;
      if (j == bp) i_rsp_ready = 1'b1;
      @(negedge clk);
    end
    i_rsp_ready = 1'b0;
    mptr = (g + 1) % N;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_zero("rst");
    @(negedge clk);
    check_zero("rst_hold");
    rst_n = 1'b1;
    mptr  = 0;
  endtask

  initial begin
    sweep_exp = '{8'hE7, 8'h81, 8'h18, 8'h7E, 8'h66, 8'h99};
    rst_n       = 1'b0;
    i_req_valid = '0;
    i_req_op    = '0;
    i_req_a     = '0;
    i_req_b     = '0;
    i_rsp_ready = 1'b0;

    // Reset with random inputs
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      i_req_valid = N'($urandom);
      i_req_op    = (3*N)'($urandom);
      i_req_a     = (W*N)'($urandom);
      i_req_b     = (W*N)'($urandom);
      i_rsp_ready = 1'($urandom);
      #1;
      check_zero("reset");
    end
    @(negedge clk);
    i_req_valid = '0;
    i_rsp_ready = 1'b0;
    rst_n       = 1'b1;
    mptr        = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("post_rst_rdy",  32'(o_req_ready), 0);
      check("post_rst_busy", 32'(o_busy),      0);
    end

    // Single request and follow-up
    set_req(2, 1'b1, 3'd5, 8'hF0, 8'h3C);
    run_txn(0);
    check("single_id",   32'(last_id),   2);
    check("single_data", 32'(last_data), 32'h00CC);
    check("single_err",  32'(last_err),  0);
    set_req(2, 1'b1, 3'd0, 8'h5A, 8'hFF);
    run_txn(0);
    check("not_data", 32'(last_data), 32'h00A5);
    i_req_valid = '0;

    // Round robin with all four requesting
    do_reset();
    for (int k = 0; k < N; k++)
      set_req(k, 1'b1, 3'(k + 1), 8'(8'h10 * k + 3), 8'h0F);
    for (int s = 0; s < 5; s++) begin
      run_txn(0);
      check("rr_id", 32'(last_id), 32'(s % N));
    end

    // Requester 1 dropped
    do_reset();
    i_req_valid[1] = 1'b0;
    begin
      int seq [4] = '{0, 2, 3, 0};
      for (int s = 0; s < 4; s++) begin
        run_txn(0);
        check("rr_drop_id", 32'(last_id), 32'(seq[s]));
      end
    end
    i_req_valid = '0;

    // Backpressure in RESP
    set_req(3, 1'b1, 3'd2, 8'hAA, 8'h0F);
    run_txn(5);
    check("bp_data", 32'(last_data), 32'h000A);
    i_req_valid = '0;

    // Illegal op, then sweep of ops 1..6
    set_req(0, 1'b1, 3'd7, 8'hFF, 8'hFF);
    run_txn(0);
    check("ill_data", 32'(last_data), 0);
    check("ill_err",  32'(last_err),  1);
    for (int op = 1; op <= 6; op++) begin
      i_req_valid = '0;
      set_req(0, 1'b1, 3'(op), 8'hC3, 8'hA5);
      run_txn(0);
      check("sweep_data", 32'(last_data), 32'(sweep_exp[op-1]));
      check("sweep_err",  32'(last_err),  0);
    end
    i_req_valid = '0;

    // Reset while in EXEC
    do_reset();
    set_req(2, 1'b1, 3'd1, 8'h11, 8'h22);
    #1;
    check("mid_acc_rdy", 32'(o_req_ready), 32'h4);
    @(negedge clk);
    check("mid_exec_busy", 32'(o_busy), 1);
    rst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    i_req_valid = '0;
    @(negedge clk);
    check_zero("mid_rst_hold");
    rst_n = 1'b1;
    mptr  = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mid_no_rsp",  32'(o_rsp_valid), 0);
      check("mid_no_busy", 32'(o_busy),      0);
    end
    set_req(1, 1'b1, 3'd5, 8'h0F, 8'hFF);
    set_req(3, 1'b1, 3'd2, 8'h0F, 8'hFF);
    run_txn(0);
    check("mid_first_id", 32'(last_id), 1);
    i_req_valid = '0;

    // Random traffic against the model
    last_g = -1;
    for (int t = 0; t < 80; t++) begin
      for (int k = 0; k < N; k++) begin
        if (k == last_g || !i_req_valid[k]) begin
          if ($urandom_range(0, 1) == 1)
            set_req(k, 1'b1, 3'($urandom), 8'($urandom), 8'($urandom));
          else
            i_req_valid[k] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          i_req_valid[k] = 1'b0;
        end
      end
      run_txn(int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
